// File: rtl/uart_cmd_parser.sv
// Purpose : ASCII command-frame parser (cmd char, 0..MAX_DIGITS lowercase hex digits, 'E')
//           between the UART RX byte stream and the bus master.
// Latency : o_valid rises on the clock edge that takes the terminating 'E'; no extra stage.
// Backpressure: a finished frame is held in HOLD until o_valid && i_ready. Bytes arriving
//           in HOLD are dropped and reported as an overrun; the parser never stalls the RX side.
//
// Ports:
//   i_clk, i_rst_n         clock (posedge), asynchronous active-low reset
//   i_data_in[7:0]         RX byte, bit 7 ignored
//   i_data_valid           RX qualifier: level with rising-edge take (EDGE_DET=1) or 1-cycle strobe
//   o_valid / i_ready      frame beat handshake
//   o_cmd[1:0]             0=R 1=W 2=A 3=S
//   o_word[DATA_W-1:0]     hex value, first digit most significant, zero-extended
//   o_ndigits              number of digits in the frame
//   o_err                  1-cycle pulse on a protocol error
//   o_err_code[2:0]        last error: 1 digit outside frame, 2 overflow, 3 overrun in HOLD,
//                          4 aborted frame, 5 stray 'E'; held until the next error
module uart_cmd_parser #(
  parameter int DATA_W     = 32,
  parameter int MAX_DIGITS = DATA_W / 4,
  parameter bit EDGE_DET   = 1'b1,
  localparam int CNT_W     = $clog2(MAX_DIGITS + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_data_in,
  input  logic              i_data_valid,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [1:0]        o_cmd,
  output logic [DATA_W-1:0] o_word,
  output logic [CNT_W-1:0]  o_ndigits,
  output logic              o_err,
  output logic [2:0]        o_err_code
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);

  state_t              state_q, state_d;
  logic                prev_vld_q;
  logic [1:0]          cmd_d;
  logic [DATA_W-1:0]   word_d;
  logic [CNT_W-1:0]    cnt_d;
  logic                err_d;
  logic [2:0]          code_d;

  logic                take;
  logic [6:0]          ch;
  logic                is_num, is_alpha, is_digit, is_cmd, is_end;
  logic [1:0]          cmd_code;
  logic [3:0]          nibble;
  logic                unused_bit7;

  assign unused_bit7 = i_data_in[7];
  assign ch          = i_data_in[6:0];

  // Level mode takes only the first cycle of a high level; strobe mode takes every strobe.
  assign take = EDGE_DET ? (i_data_valid & ~prev_vld_q) : i_data_valid;

  assign is_num   = (ch >= 7'h30) && (ch <= 7'h39);   // '0'..'9'
  assign is_alpha = (ch >= 7'h61) && (ch <= 7'h66);   // 'a'..'f'
  assign is_digit = is_num || is_alpha;
  assign is_end   = (ch == 7'h45);                    // 'E'
  // 'a'..'f' have low nibble 1..6, so +9 maps them onto 10..15.
  assign nibble   = is_num ? ch[3:0] : (ch[3:0] + 4'd9);

  always_comb begin
    is_cmd   = 1'b1;
    cmd_code = 2'd0;
    case (ch)
      7'h52:   cmd_code = 2'd0;   // 'R'
      7'h57:   cmd_code = 2'd1;   // 'W'
      7'h41:   cmd_code = 2'd2;   // 'A'
      7'h53:   cmd_code = 2'd3;   // 'S'
      default: is_cmd   = 1'b0;
    endcase
  end

  assign o_valid = (state_q == S_HOLD);

  always_comb begin
    state_d = state_q;
    cmd_d   = o_cmd;
    word_d  = o_word;
    cnt_d   = o_ndigits;
    err_d   = 1'b0;
    code_d  = o_err_code;

    case (state_q)
      S_IDLE: begin
        if (take) begin
          if (is_cmd) begin
            cmd_d   = cmd_code;
            word_d  = '0;
            cnt_d   = '0;
            state_d = S_COLLECT;
          end else if (is_digit) begin
            err_d  = 1'b1;
            code_d = 3'd1;
          end else if (is_end) begin
            err_d  = 1'b1;
            code_d = 3'd5;
          end
        end
      end

      S_COLLECT: begin
        if (take) begin
          if (is_digit) begin
            if (o_ndigits < MAX_CNT) begin
              word_d = (o_word << 4) | DATA_W'(nibble);
              cnt_d  = o_ndigits + CNT_W'(1);
            end else begin
              err_d   = 1'b1;
              code_d  = 3'd2;
              state_d = S_DISCARD;
            end
          end else if (is_cmd) begin
            // A new command mid-frame aborts the old one and starts afresh.
            err_d  = 1'b1;
            code_d = 3'd4;
            cmd_d  = cmd_code;
            word_d = '0;
            cnt_d  = '0;
          end else if (is_end) begin
            state_d = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        // Beat fields stay frozen here; only the state and error flags may move.
        if (i_ready) begin
          state_d = S_IDLE;
        end
        if (take && (is_digit || is_cmd || is_end)) begin
          err_d  = 1'b1;
          code_d = 3'd3;
        end
      end

      S_DISCARD: begin
        if (take && is_cmd) begin
          cmd_d   = cmd_code;
          word_d  = '0;
          cnt_d   = '0;
          state_d = S_COLLECT;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      prev_vld_q <= 1'b0;
      o_cmd      <= '0;
      o_word     <= '0;
      o_ndigits  <= '0;
      o_err      <= 1'b0;
      o_err_code <= '0;
    end else begin
      state_q    <= state_d;
      prev_vld_q <= i_data_valid;
      o_cmd      <= cmd_d;
      o_word     <= word_d;
      o_ndigits  <= cnt_d;
      o_err      <= err_d;
      o_err_code <= code_d;
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
module tb_uart_cmd_parser;

  localparam int DATA_W = 32;
  localparam int MAXD   = 8;
  localparam int CNT_W  = $clog2(MAXD + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        data_in = 8'h00;
  logic              data_valid = 1'b0;
  logic              ready = 1'b0;
  logic              o_valid;
  logic [1:0]        o_cmd;
  logic [DATA_W-1:0] o_word;
  logic [CNT_W-1:0]  o_ndigits;
  logic              o_err;
  logic [2:0]        o_err_code;

  always #5 clk = ~clk;

  uart_cmd_parser #(
    .DATA_W    (DATA_W),
    .MAX_DIGITS(MAXD),
    .EDGE_DET  (1'b1)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_data_in   (data_in),
    .i_data_valid(data_valid),
    .o_valid     (o_valid),
    .i_ready     (ready),
    .o_cmd       (o_cmd),
    .o_word      (o_word),
    .o_ndigits   (o_ndigits),
    .o_err       (o_err),
    .o_err_code  (o_err_code)
  );

  typedef struct {
    logic [1:0]        cmd;
    logic [DATA_W-1:0] word;
    int                nd;
  } beat_t;

  beat_t beat_q[$];
  int    err_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  // Reference model: where we are in the character stream, the digits seen so far,
  // and whether a finished frame is still waiting for the consumer.
  int mode;          // 0 outside a frame, 1 inside a frame, 2 skipping an overflowed frame
  int digits[$];
  int cur_cmd;
  bit pending;
  bit tb_prev;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // 0 ignore, 1 hex digit, 2 command, 3 end
  function automatic int classify(input logic [7:0] b);
    int c = int'(b[6:0]);
    if ((c >= 8'h30 && c <= 8'h39) || (c >= 8'h61 && c <= 8'h66)) return 1;
    if (c == 8'h52 || c == 8'h57 || c == 8'h41 || c == 8'h53) return 2;
    if (c == 8'h45) return 3;
    return 0;
  endfunction

  function automatic int digit_val(input logic [7:0] b);
    int c = int'(b[6:0]);
    return (c <= 8'h39) ? c - 8'h30 : c - 8'h61 + 10;
  endfunction

  function automatic int cmd_index(input logic [7:0] b);
    case (b[6:0])
      7'h52:   return 0;
      7'h57:   return 1;
      7'h41:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic start_frame(input logic [7:0] b);
    cur_cmd = cmd_index(b);
    digits.delete();
    mode = 1;
  endtask

  task automatic model_step(input bit take, input logic [7:0] b, input bit rdy);
    bit    hs = pending && rdy;
    int    k;
    beat_t e;
    longint unsigned w;
    if (take) begin
      k = classify(b);
      if (pending) begin
        if (k != 0) err_q.push_back(3);
      end else begin
        case (mode)
          0: begin
            if (k == 2) start_frame(b);
            else if (k == 1) err_q.push_back(1);
            else if (k == 3) err_q.push_back(5);
          end
          1: begin
            if (k == 1) begin
              if (digits.size() < MAXD) digits.push_back(digit_val(b));
              else begin
                err_q.push_back(2);
                mode = 2;
              end
            end else if (k == 2) begin
              err_q.push_back(4);
              start_frame(b);
            end else if (k == 3) begin
              w = 0;
              foreach (digits[i]) w = w * 16 + longint'(digits[i]);
              e.cmd  = 2'(cur_cmd);
              e.word = DATA_W'(w);
              e.nd   = digits.size();
              beat_q.push_back(e);
              pending = 1'b1;
              mode    = 0;
            end
          end
          default: begin
            if (k == 2) start_frame(b);
          end
        endcase
      end
    end
    if (hs) pending = 1'b0;
  endtask

  // One clock of stimulus, driven on the falling edge and applied to the model.
  task automatic cycle(input bit vld, input logic [7:0] b, input bit rdy);
    bit take;
    @(negedge clk);
    data_in    = b;
    data_valid = vld;
    ready      = rdy;
    take       = vld && !tb_prev;
    tb_prev    = vld;
    model_step(take, b, rdy);
  endtask

  task automatic send(input logic [7:0] b, input bit rdy);
    cycle(1'b1, b, rdy);
    cycle(1'b0, 8'h00, rdy);
  endtask

  task automatic send_str(input string s, input bit rdy);
    for (int i = 0; i < s.len(); i++) send(s[i], rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) cycle(1'b0, 8'h00, rdy);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n      = 1'b0;
    data_valid = 1'b0;
    tb_prev    = 1'b0;
    mode       = 0;
    pending    = 1'b0;
    digits.delete();
    beat_q.delete();
    err_q.delete();
    #1;
    chk({tag, "_valid"},    o_valid,    0);
    chk({tag, "_cmd"},      o_cmd,      0);
    chk({tag, "_word"},     o_word,     0);
    chk({tag, "_ndigits"},  o_ndigits,  0);
    chk({tag, "_err"},      o_err,      0);
    chk({tag, "_err_code"}, o_err_code, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: samples just before each rising edge, when inputs and outputs are settled.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) continue;
      if (o_valid) begin
        chk("beat_expected", beat_q.size() != 0, 1);
        if (beat_q.size() != 0) begin
          e = beat_q[0];
          chk("beat_cmd",     o_cmd,     e.cmd);
          chk("beat_word",    o_word,    e.word);
          chk("beat_ndigits", o_ndigits, e.nd);
          if (ready) void'(beat_q.pop_front());
        end
      end
      if (o_err) begin
        chk("err_expected", err_q.size() != 0, 1);
        if (err_q.size() != 0) chk("err_code", o_err_code, err_q.pop_front());
      end
    end
  end

  string cmd_chars = "RWAS";
  string dig_chars = "0123456789abcdef";
  string ign_chars = " xZ.GBFr\n";

  initial begin
    logic [7:0] b;
    int r;
    mode = 0; pending = 0; tb_prev = 0;

    do_reset("reset");

    // Full-width frame
    send_str("A1234abcdE", 1'b1);
    idle(3, 1'b1);

    // Backpressure for 20 cycles, then accept
    send_str("W7fE", 1'b0);
    idle(20, 1'b0);
    idle(3, 1'b1);

    // Overflow then a good frame
    send_str("R123456789E", 1'b1);
    send_str("R5E", 1'b1);
    idle(3, 1'b1);

    // Digit outside frame, aborted frame, ignored chars, stray 'E'
    send_str("5", 1'b1);
    send_str("W1R2E", 1'b1);
    send_str("x E", 1'b1);
    idle(3, 1'b1);

    // Overrun while holding, then release
    send_str("S0E", 1'b0);
    send_str("3", 1'b0);
    idle(4, 1'b0);
    idle(3, 1'b1);

    // Bit 7 must not affect classification
    send(8'hD7, 1'b1);            // 'W' with bit 7 set
    send(8'hB9, 1'b1);            // '9'
    send(8'hC5, 1'b1);            // 'E'
    idle(3, 1'b1);

    // Reset while a beat is being held
    send_str("W1E", 1'b0);
    idle(2, 1'b0);
    do_reset("reset_hold");

    // Level-mode valid held high: one take only
    repeat (10) cycle(1'b1, 8'h52, 1'b1);
    idle(2, 1'b1);
    send_str("5E", 1'b1);
    idle(3, 1'b1);

    // Reset mid-frame, then empty frame
    send_str("A12", 1'b1);
    do_reset("reset_mid");
    send_str("AE", 1'b1);
    idle(3, 1'b1);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 12)      b = cmd_chars[$urandom_range(0, cmd_chars.len() - 1)];
      else if (r < 52) b = dig_chars[$urandom_range(0, dig_chars.len() - 1)];
      else if (r < 70) b = 8'h45;
      else             b = ign_chars[$urandom_range(0, ign_chars.len() - 1)];
      if ($urandom_range(0, 3) == 0) b = b | 8'h80;
      cycle(1'b1, b, $urandom_range(0, 9) < 7);
      repeat ($urandom_range(1, 3)) cycle(1'b0, 8'h00, $urandom_range(0, 9) < 7);
    end

    idle(20, 1'b1);
    chk("beat_queue_drained", beat_q.size(), 0);
    chk("err_queue_drained",  err_q.size(),  0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
